// File: rtl/nfc_cmd_arbiter.sv
// nfc_cmd_arbiter: multi-channel command front end for the NAND flash
// controller. Each host channel has its own command FIFO; a round-robin
// arbiter feeds one command at a time to the single NFC command port, waits
// for nfc_done (or a watchdog timeout) and pulses a completion status back to
// the channel that issued the command.
module nfc_cmd_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int CMD_W   = 3,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*CMD_W-1:0]    req_cmd,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  output logic [NUM_CH-1:0]          rsp_valid,
  output logic [1:0]                 rsp_status,
  output logic [CMD_W-1:0]           nfc_cmd,
  output logic [ADDR_W-1:0]          RWA,
  output logic                       nfc_start,
  input  logic                       nfc_done,
  input  logic                       command_error,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  grant_ch
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = CMD_W + ADDR_W;
  localparam int WD_W  = $clog2(TIMEOUT);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  localparam logic [AW:0]         PTR_ONE  = (AW+1)'(1);
  localparam logic [WD_W-1:0]     WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]     WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [NUM_CH-1:0]   CH_ONE   = NUM_CH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_d;

  // Per-channel FIFO status, head entries and pop strobes.
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_pop;
  logic [ENT_W-1:0]  fifo_head [NUM_CH];

  // Arbiter and datapath registers plus their next-state values.
  logic [CH_W-1:0]   last_grant, last_grant_d;
  logic [CH_W-1:0]   grant_d;
  logic [WD_W-1:0]   wd, wd_d;
  logic [CMD_W-1:0]  nfc_cmd_d;
  logic [ADDR_W-1:0] rwa_d;
  logic              nfc_start_d;
  logic [NUM_CH-1:0] rsp_valid_d;
  logic [1:0]        rsp_status_d;
  logic              busy_d;
  logic              pop_en;

  logic              rr_found;
  logic [CH_W-1:0]   rr_pick;
  logic [CH_W-1:0]   rr_idx;

  // ---------------------------------------------------------------------------
  // Command FIFOs: one per channel, entries are {cmd, addr}. The pointers carry
  // one extra wrap bit so that full (wrap bits differ) and empty (pointers
  // equal) can be told apart without a separate counter.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;

    assign push          = req_valid[g] & ~fifo_full[g];
    assign fifo_full[g]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty[g] = (wr_ptr == rd_ptr);
    assign fifo_head[g]  = mem[rd_ptr[AW-1:0]];
    assign fifo_pop[g]   = pop_en && (rr_pick == CH_W'(g));

    // Write the incoming command into the slot under the write pointer.
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving the RAM unreset lets it map onto plain
    // memory cells.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {req_cmd[g*CMD_W +: CMD_W], req_addr[g*ADDR_W +: ADDR_W]};
      end
    end

    // Advance read/write pointers; a same-cycle push and pop both take effect.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)        wr_ptr <= wr_ptr + PTR_ONE;
        if (fifo_pop[g]) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  assign req_ready = ~fifo_full;

  // Round-robin pick: first non-empty channel starting at last_grant+1.
  // Iterating from the farthest candidate down lets the nearest one win.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      rr_idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!fifo_empty[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    state_d      = state;
    pop_en       = 1'b0;
    nfc_start_d  = 1'b0;
    rsp_valid_d  = '0;
    rsp_status_d = rsp_status;
    nfc_cmd_d    = nfc_cmd;
    rwa_d        = RWA;
    grant_d      = grant_ch;
    last_grant_d = last_grant;
    wd_d         = wd;

    case (state)
      S_IDLE: begin
        if (rr_found) begin
          pop_en               = 1'b1;
          {nfc_cmd_d, rwa_d}   = fifo_head[rr_pick];
          grant_d              = rr_pick;
          nfc_start_d          = 1'b1;
          state_d              = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final watchdog cycle still counts as a completion.
        if (nfc_done) begin
          rsp_status_d = command_error ? ST_ERR : ST_OK;
          rsp_valid_d  = CH_ONE << grant_ch;
          state_d      = S_RESP;
        end else if (wd == WD_LAST) begin
          rsp_status_d = ST_TMO;
          rsp_valid_d  = CH_ONE << grant_ch;
          state_d      = S_RESP;
        end else begin
          wd_d = wd + WD_ONE;
        end
      end
      S_RESP: begin
        last_grant_d = grant_ch;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Registered outputs, arbiter history and watchdog.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      nfc_cmd    <= '0;
      RWA        <= '0;
      nfc_start  <= 1'b0;
      rsp_valid  <= '0;
      rsp_status <= ST_OK;
      busy       <= 1'b0;
      grant_ch   <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      wd         <= '0;
    end else begin
      nfc_cmd    <= nfc_cmd_d;
      RWA        <= rwa_d;
      nfc_start  <= nfc_start_d;
      rsp_valid  <= rsp_valid_d;
      rsp_status <= rsp_status_d;
      busy       <= busy_d;
      grant_ch   <= grant_d;
      last_grant <= last_grant_d;
      wd         <= wd_d;
    end
  end

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Self-checking bench for nfc_cmd_arbiter (4 channels, TIMEOUT=16).
// Accepted pushes and driven completions go into expected queues; a monitor
// records nfc_start and rsp_valid events, and each scenario task pops and
// compares them.
module tb_nfc_cmd_arbiter;

  localparam int NUM_CH  = 4;
  localparam int CMD_W   = 3;
  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [1:0]  ch;
    logic [2:0]  cmd;
    logic [15:0] addr;
  } issue_t;

  typedef struct {
    int          cyc;
    logic [1:0]  grant;
    logic [2:0]  cmd;
    logic [15:0] addr;
  } start_t;

  typedef struct {
    int         cyc;
    logic [3:0] valid;
    logic [1:0] status;
  } rsp_t;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
    logic [1:0] status;
  } rsp_exp_t;

  logic        clk;
  logic        Reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_cmd;
  logic [63:0] req_addr;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_status;
  logic [2:0]  nfc_cmd;
  logic [15:0] RWA;
  logic        nfc_start;
  logic        nfc_done;
  logic        command_error;
  logic        busy;
  logic [1:0]  grant_ch;

  issue_t   exp_issue [$];
  rsp_exp_t exp_rsp   [$];
  start_t   obs_start [$];
  rsp_t     obs_rsp   [$];
  start_t   mon_s;
  rsp_t     mon_r;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [32:0] RESET_VEC = {4'hF, 4'h0, 2'b00, 1'b0, 3'b000, 16'h0000, 1'b0, 2'b00};

  nfc_cmd_arbiter #(
    .NUM_CH(NUM_CH), .CMD_W(CMD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .nfc_cmd(nfc_cmd), .RWA(RWA), .nfc_start(nfc_start),
    .nfc_done(nfc_done), .command_error(command_error),
    .busy(busy), .grant_ch(grant_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log start and response pulses in the middle of each cycle.
  always @(negedge clk) begin
    if (Reset) begin
      if (nfc_start) begin
        mon_s.cyc = cyc; mon_s.grant = grant_ch; mon_s.cmd = nfc_cmd; mon_s.addr = RWA;
        obs_start.push_back(mon_s);
      end
      if (rsp_valid != 4'h0) begin
        mon_r.cyc = cyc; mon_r.valid = rsp_valid; mon_r.status = rsp_status;
        obs_rsp.push_back(mon_r);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "bench time limit exceeded");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push1(input int ch, input logic [2:0] c, input logic [15:0] a,
                       output bit acc, output int drive_cyc);
    issue_t e;
    drive_cyc = cyc;
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_cmd[ch*3 +: 3]   = c;
    req_addr[ch*16 +: 16] = a;
    acc = req_ready[ch];
    if (acc) begin
      e.ch = 2'(ch); e.cmd = c; e.addr = a;
      exp_issue.push_back(e);
    end
    step();
    req_valid = '0;
  endtask

  task automatic push_all(input logic [3:0] mask, input logic [7:0] tag,
                          output logic [3:0] acc, output int drive_cyc);
    issue_t e;
    drive_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]         = mask[i];
      req_cmd[i*3 +: 3]    = 3'(i + 1);
      req_addr[i*16 +: 16] = {tag, 8'(i)};
    end
    acc = req_ready & mask;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        e.ch = 2'(i); e.cmd = 3'(i + 1); e.addr = {tag, 8'(i)};
        exp_issue.push_back(e);
      end
    end
    step();
    req_valid = '0;
  endtask

  // Play the NFC for one command: expect a start for exp_ch, then either
  // return nfc_done 'delay' cycles after the start or let the watchdog fire.
  task automatic serve_one(input int exp_ch, input int delay, input bit err,
                           input bit give_done, input int exp_start, output int start_cyc);
    start_t   s;
    issue_t   e;
    rsp_t     r;
    rsp_exp_t x;
    int       idx;
    int       budget;
    start_cyc = -1;
    budget = 0;
    while (obs_start.size() == 0 && budget < 64) begin step(); budget++; end
    n_cmp++;
    if (obs_start.size() == 0) begin
      n_fail++;
      $display("FAIL start_wait ch%0d: no nfc_start within 64 cycles, required one", exp_ch);
      return;
    end
    s = obs_start.pop_front();
    start_cyc = s.cyc;
    n_cmp++;
    if (s.grant !== 2'(exp_ch)) begin
      n_fail++;
      $display("FAIL grant: got ch%0d, required ch%0d", s.grant, exp_ch);
    end
    if (exp_start >= 0) begin
      n_cmp++;
      if (s.cyc != exp_start) begin
        n_fail++;
        $display("FAIL start_cycle ch%0d: got cycle %0d, required %0d", exp_ch, s.cyc, exp_start);
      end
    end
    idx = -1;
    foreach (exp_issue[i]) if (idx < 0 && exp_issue[i].ch == 2'(exp_ch)) idx = i;
    n_cmp++;
    e = '0;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL issue_sb ch%0d: cmd=%b addr=%h issued, required no command pending", exp_ch, s.cmd, s.addr);
    end else begin
      e = exp_issue[idx];
      exp_issue.delete(idx);
      if ({s.cmd, s.addr} !== {e.cmd, e.addr}) begin
        n_fail++;
        $display("FAIL issue_data ch%0d: got cmd=%b addr=%h, required cmd=%b addr=%h",
                 exp_ch, s.cmd, s.addr, e.cmd, e.addr);
      end
    end
    x.ch = 2'(exp_ch);
    if (give_done) begin
      while (cyc < s.cyc + delay) step();
      if (idx >= 0) begin
        n_cmp++;
        if ({busy, nfc_cmd, RWA} !== {1'b1, e.cmd, e.addr}) begin
          n_fail++;
          $display("FAIL hold_in_wait ch%0d: got busy=%b cmd=%b addr=%h, required busy=1 cmd=%b addr=%h",
                   exp_ch, busy, nfc_cmd, RWA, e.cmd, e.addr);
        end
      end
      nfc_done = 1'b1;
      command_error = err;
      x.status = err ? 2'b01 : 2'b00;
      x.cyc = cyc + 1;
      exp_rsp.push_back(x);
      step();
      nfc_done = 1'b0;
      command_error = 1'b0;
    end else begin
      x.status = 2'b10;
      x.cyc = s.cyc + TIMEOUT + 1;
      exp_rsp.push_back(x);
    end
    budget = 0;
    while (obs_rsp.size() == 0 && budget < TIMEOUT + 32) begin step(); budget++; end
    n_cmp++;
    if (obs_rsp.size() == 0) begin
      n_fail++;
      $display("FAIL rsp_wait ch%0d: no rsp_valid within %0d cycles, required one", exp_ch, TIMEOUT + 32);
      void'(exp_rsp.pop_front());
      return;
    end
    r = obs_rsp.pop_front();
    x = exp_rsp.pop_front();
    n_cmp++;
    if ({r.valid, r.status} !== {4'b0001 << x.ch, x.status}) begin
      n_fail++;
      $display("FAIL rsp ch%0d: got valid=%b status=%b, required valid=%b status=%b",
               exp_ch, r.valid, r.status, 4'b0001 << x.ch, x.status);
    end
    n_cmp++;
    if (r.cyc != x.cyc) begin
      n_fail++;
      $display("FAIL rsp_cycle ch%0d: got cycle %0d, required %0d", exp_ch, r.cyc, x.cyc);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_status, nfc_start, nfc_cmd, RWA, busy, grant_ch} !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h",
               {req_ready, rsp_valid, rsp_status, nfc_start, nfc_cmd, RWA, busy, grant_ch}, RESET_VEC);
    end
    Reset = 1'b1;
    repeat (2) step();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_status, nfc_start, nfc_cmd, RWA, busy, grant_ch} !== RESET_VEC) begin
      n_fail++;
      $display("FAIL idle_after_release: got %h, required %h",
               {req_ready, rsp_valid, rsp_status, nfc_start, nfc_cmd, RWA, busy, grant_ch}, RESET_VEC);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] acc;
    int dc, sc, prev;
    push_all(4'hF, 8'hA0, acc, dc);
    n_cmp++;
    if (acc !== 4'hF) begin
      n_fail++;
      $display("FAIL rr_preload: accepted %b, required 1111", acc);
    end
    prev = dc + 2;
    // nfc_done in the first WAIT cycle: starts come exactly 4 cycles apart.
    for (int i = 0; i < 4; i++) begin
      serve_one(i, 1, 1'b0, 1'b1, (i == 0) ? dc + 2 : prev + 4, sc);
      prev = sc;
    end
    push_all(4'b1001, 8'hB0, acc, dc);
    serve_one(0, 2, 1'b0, 1'b1, dc + 2, sc);
    serve_one(3, 2, 1'b0, 1'b1, -1, sc);
  endtask

  task automatic test_single();
    bit acc;
    int dc, sc;
    push1(2, 3'b010, 16'h1A2B, acc, dc);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept: req_ready[2]=%b at push, required 1", acc);
    end
    serve_one(2, 10, 1'b0, 1'b1, dc + 2, sc);
    step();
    n_cmp++;
    if ({busy, nfc_start} !== 2'b00 || obs_start.size() != 0) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b nfc_start=%b extra_starts=%0d, required 0/0/0",
               busy, nfc_start, obs_start.size());
    end
  endtask

  task automatic test_fifo_wrap();
    bit acc;
    int dc, sc;
    push1(0, 3'b001, 16'h0C00, acc, dc);
    for (int k = 0; k < 4; k++) begin
      push1(1, 3'(k), 16'h1100 + 16'(k), acc, dc);
      n_cmp++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_accept #%0d: req_ready[1]=%b, required 1", k, acc);
      end
    end
    n_cmp++;
    if (req_ready !== 4'b1101) begin
      n_fail++;
      $display("FAIL full_ready: req_ready=%b, required 1101", req_ready);
    end
    push1(1, 3'b111, 16'hDEAD, acc, dc);
    n_cmp++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL full_reject: 5th push accepted=%b, required 0", acc);
    end
    serve_one(0, 1, 1'b0, 1'b1, -1, sc);
    for (int k = 0; k < 6; k++) begin
      serve_one(1, 2, 1'b0, 1'b1, -1, sc);
      if (k < 2) begin
        push1(1, 3'(k + 4), 16'h1104 + 16'(k), acc, dc);
        n_cmp++;
        if (acc !== 1'b1) begin
          n_fail++;
          $display("FAIL refill_accept #%0d: req_ready[1]=%b, required 1", k, acc);
        end
      end
    end
  endtask

  task automatic test_error_timeout();
    bit acc;
    int dc, sc;
    push1(3, 3'b101, 16'hBEEF, acc, dc);
    serve_one(3, 5, 1'b1, 1'b1, dc + 2, sc);
    push1(0, 3'b110, 16'h0F0F, acc, dc);
    serve_one(0, 0, 1'b0, 1'b0, dc + 2, sc);
    nfc_done = 1'b1;
    step();
    nfc_done = 1'b0;
    repeat (8) step();
    n_cmp++;
    if (obs_rsp.size() + obs_start.size() != 0) begin
      n_fail++;
      $display("FAIL late_done: %0d rsp and %0d start events after late nfc_done, required 0/0",
               obs_rsp.size(), obs_start.size());
    end
  endtask

  task automatic test_simul_done();
    bit acc;
    int dc, sc;
    push1(1, 3'b100, 16'h7777, acc, dc);
    serve_one(1, TIMEOUT, 1'b0, 1'b1, dc + 2, sc);
  endtask

  task automatic test_reset_mid();
    bit acc;
    logic [3:0] am;
    int dc, sc, budget;
    push1(2, 3'b011, 16'h5555, acc, dc);
    budget = 0;
    while (obs_start.size() == 0 && budget < 16) begin step(); budget++; end
    push1(0, 3'b001, 16'hAAA0, acc, dc);
    push1(0, 3'b010, 16'hAAA1, acc, dc);
    Reset = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_status, nfc_start, nfc_cmd, RWA, busy, grant_ch} !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_mid_values: got %h, required %h",
               {req_ready, rsp_valid, rsp_status, nfc_start, nfc_cmd, RWA, busy, grant_ch}, RESET_VEC);
    end
    exp_issue.delete();
    exp_rsp.delete();
    obs_start.delete();
    obs_rsp.delete();
    repeat (2) step();
    Reset = 1'b1;
    repeat (30) step();
    n_cmp++;
    if (obs_start.size() + obs_rsp.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: %0d starts %0d rsps busy=%b, required 0/0/0",
               obs_start.size(), obs_rsp.size(), busy);
    end
    // Arbiter history must be back at its reset value: channel 1 before 2.
    push_all(4'b0110, 8'hC0, am, dc);
    serve_one(1, 3, 1'b0, 1'b1, dc + 2, sc);
    serve_one(2, 3, 1'b0, 1'b1, -1, sc);
  endtask

  initial begin
    Reset         = 1'b0;
    req_valid     = '0;
    req_cmd       = '0;
    req_addr      = '0;
    nfc_done      = 1'b0;
    command_error = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_fifo_wrap();
    test_error_timeout();
    test_simul_done();
    test_reset_mid();
    n_cmp++;
    if (exp_issue.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_commands: %0d expected commands never issued, required 0", exp_issue.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nfc_cmd_arbiter.md
# nfc_cmd_arbiter

Parametrised multi-host command front end for the NAND flash controller (NFC). It accepts flash commands from `NUM_CH` independent host channels and buffers each channel's commands in its own FIFO. It serialises the commands onto the single NFC command port (`nfc_cmd`/`RWA`/`nfc_start`/`nfc_done`/`command_error`) using round-robin arbitration, and returns a per-command completion status to the issuing channel. It also adds a completion watchdog: a missing `nfc_done` is reported as a timeout instead of hanging the port.

## Interface
Parameters:
- `NUM_CH`, 4: number of host channels (2..8).
- `CMD_W`, 3: NFC command opcode width.
- `ADDR_W`, 16: row/word address width (`RWA`).
- `DEPTH`, 4: per-channel FIFO depth (power of two, ≥2).
- `TIMEOUT`, 4096: cycles allowed in WAIT before declaring a timeout (≥2).

Ports:
- `clk`  in  1  system clock; all flops are on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_CH  per-channel command valid.
- `req_ready`  out  NUM_CH  per-channel FIFO not full.
- `req_cmd`  in  NUM_CH*CMD_W  packed opcodes; channel i occupies bits [i*CMD_W +: CMD_W].
- `req_addr`  in  NUM_CH*ADDR_W  packed addresses, packed the same way.
- `rsp_valid`  out  NUM_CH  one-cycle completion pulse to the issuing channel.
- `rsp_status`  out  2  completion status: 00 ok, 01 command_error, 10 timeout; valid while any `rsp_valid` bit is high.
- `nfc_cmd`  out  CMD_W  opcode to the NFC.
- `RWA`  out  ADDR_W  address to the NFC.
- `nfc_start`  out  1  one-cycle start pulse.
- `nfc_done`  in  1  NFC completion.
- `command_error`  in  1  NFC error flag, sampled only when `nfc_done` is high.
- `busy`  out  1  high in every state except IDLE.
- `grant_ch`  out  $clog2(NUM_CH)  channel currently owning the NFC.

## Operation
- **FIFOs:** one FIFO per channel, DEPTH entries of {cmd, addr}.
  - Push when `req_valid[i] & req_ready[i]`.
  - `req_ready[i] = !full[i]`, combinational from FIFO state.
  - A push to a full FIFO cannot occur because ready is low; the data is not consumed.
  - Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
  - A push and a pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
- **State machine:** IDLE → ISSUE → WAIT → RESP → IDLE.
  - **IDLE:** if any FIFO is non-empty, pick the first non-empty channel searching from `last_grant+1` modulo NUM_CH. Pop its head into the command register, set `grant_ch`, go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE:** `nfc_start`=1 for exactly this one cycle. Clear the watchdog, go to WAIT.
  - **WAIT:** the watchdog increments each cycle.
    - `nfc_done`=1: capture status (`command_error` ? 01 : 00), go to RESP.
    - Else if the watchdog reaches TIMEOUT-1: status 10, go to RESP.
    - If `nfc_done` and timeout occur in the same cycle, `nfc_done` wins.
  - **RESP:** `rsp_valid[grant_ch]`=1 and `rsp_status` driven for one cycle. `last_grant <= grant_ch`, go to IDLE.
- `nfc_cmd`/`RWA` are registered. They are loaded on the IDLE→ISSUE transition and held stable through ISSUE, WAIT and RESP.
- `nfc_done` is ignored outside WAIT. This includes a late `nfc_done` arriving after a timeout.
- All outputs except `req_ready` are registered.

## Timing
- **Reset values:** state IDLE, all FIFOs empty, `req_ready` all 1, `rsp_valid`=0, `rsp_status`=00, `nfc_start`=0, `nfc_cmd`=0, `RWA`=0, `busy`=0, `grant_ch`=0. `last_grant`=NUM_CH-1, so channel 0 has first priority.
- Asserting `Reset` mid-command clears all state immediately. Queued and in-flight commands are discarded and no `rsp_valid` is produced.
- **Latency:** a request accepted at edge t into an idle block gives `nfc_start` high in the cycle after edge t+1. `nfc_done` sampled high at edge d gives `rsp_valid` high in the cycle after edge d. IDLE is re-entered one edge later.
- **Back-to-back commands:** minimum 4 cycles between `nfc_start` pulses with `nfc_done` returned in the first WAIT cycle (ISSUE, WAIT, RESP, IDLE).
- **Fairness:** with all channels continuously non-empty, grants rotate 0,1,…,NUM_CH-1,0. Each channel waits at most NUM_CH-1 commands.
- **Timeout:** with no `nfc_done`, `rsp_valid` with status 10 is high exactly TIMEOUT+1 cycles after the `nfc_start` cycle.

## Test plan
- **Reset and single command:** release `Reset`; channel 2 pushes cmd=3'b010, addr=16'h1A2B. Expect `nfc_start` for one cycle with `nfc_cmd`=010 and `RWA`=1A2B. Drive `nfc_done` 10 cycles later → `rsp_valid`=4'b0100, `rsp_status`=00.
- **Round robin:** preload one command in every channel of a 4-channel build. Ack each with `nfc_done` → grants 0,1,2,3. Refill channels 0 and 3 only → next grants 0,3.
- **FIFO full/wrap:** hold the NFC in WAIT; push 4 commands on channel 1 → `req_ready[1]`=0. A 5th valid is not accepted. Complete 6 commands while pushing more → addresses emerge in push order across pointer wrap.
- **Error and timeout:** `nfc_done` with `command_error`=1 → status 01. With TIMEOUT=16 and no `nfc_done` → status 10 at 17 cycles after `nfc_start`. A late `nfc_done` afterwards produces no extra `rsp_valid`.
- **Simultaneous timeout/done and reset mid-op:** `nfc_done` in the timeout cycle → status 00. Assert `Reset` in WAIT with 2 queued commands → outputs at reset values. No response or `nfc_start` follows release until new pushes arrive.
